// File: rtl/iir_out_decimator_if.sv
// Valid/ready bundle between the IIR output decimator and its producer/consumer.
// The producer/consumer side uses the master modport; the decimator uses slave.
interface iir_out_decimator_if #(
    parameter int WORD_LEN_IN  = 16,
    parameter int WORD_LEN_OUT = 16
);
    logic                    in_valid;
    logic [WORD_LEN_IN-1:0]  in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic [WORD_LEN_OUT-1:0] out_data;
    logic                    out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/iir_out_decimator.sv
// Accumulate-and-dump decimator for the IIR output, with round-half-up requantization,
// saturation and an output FIFO. Optional saturation counter: IIR_DEC_SAT_CNT_EN.
module iir_out_decimator #(
    parameter int WORD_LEN_IN   = 16,
    parameter int WORD_FRAC_IN  = 14,
    parameter int WORD_LEN_OUT  = 16,
    parameter int WORD_FRAC_OUT = 15,
    parameter int DECIM_LOG2    = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    iir_out_decimator_if.slave   bus,
    output logic                 sat_flag,
    input  logic                 sat_clr
`ifdef IIR_DEC_SAT_CNT_EN
    ,
    output logic [15:0]          sat_cnt
`endif
);
    localparam int D      = 1 << DECIM_LOG2;
    localparam int ACC_W  = WORD_LEN_IN + DECIM_LOG2;
    localparam int CNT_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int S      = DECIM_LOG2 + WORD_FRAC_IN - WORD_FRAC_OUT;
    localparam int LSH    = (S < 0) ? -S : 0;
    localparam int BASE_W = ((ACC_W + LSH) > WORD_LEN_OUT) ? (ACC_W + LSH) : WORD_LEN_OUT;
    localparam int WIDE_W = BASE_W + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    localparam logic signed [WIDE_W-1:0] OUT_MAX =
        {{(WIDE_W-WORD_LEN_OUT+1){1'b0}}, {(WORD_LEN_OUT-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] OUT_MIN =
        {{(WIDE_W-WORD_LEN_OUT+1){1'b1}}, {(WORD_LEN_OUT-1){1'b0}}};

    logic signed [ACC_W-1:0]  acc_r;
    logic [CNT_W-1:0]         cnt_r;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [WIDE_W-1:0] sum_wide_s;
    logic signed [WIDE_W-1:0] scaled_s;
    logic [WORD_LEN_OUT-1:0]  q_s;
    logic                     sat_s;
    logic                     last_s;
    logic                     full_s;
    logic                     in_ready_s;
    logic                     accept_s;
    logic                     push_s;
    logic                     pop_s;
    logic [WORD_LEN_OUT-1:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_r;
    logic [PTR_W-1:0]         rd_ptr_r;
    logic [OCC_W-1:0]         occ_r;
    logic [OCC_W-1:0]         occ_nxt_s;
    logic                     out_valid_r;
    logic                     sat_flag_r;

    // A dump is only offered when the FIFO can take it, so no result is ever dropped.
    assign last_s     = (cnt_r == CNT_W'(D - 1));
    assign full_s     = (occ_r == OCC_W'(FIFO_DEPTH));
    assign in_ready_s = !last_s || !full_s;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign push_s     = accept_s && last_s;
    assign pop_s      = out_valid_r && bus.out_ready;

    assign sum_s      = acc_r + ACC_W'($signed(bus.in_data));
    assign sum_wide_s = WIDE_W'(sum_s);

    if (S > 0) begin : g_rshift
        localparam logic signed [WIDE_W-1:0] HALF = {{(WIDE_W-1){1'b0}}, 1'b1} << (S - 1);
        assign scaled_s = (sum_wide_s + HALF) >>> S;
    end else if (S == 0) begin : g_pass
        assign scaled_s = sum_wide_s;
    end else begin : g_lshift
        assign scaled_s = sum_wide_s <<< LSH;
    end

    // Clip the requantized sum to the output word range.
    always_comb begin
        sat_s = 1'b0;
        q_s   = scaled_s[WORD_LEN_OUT-1:0];
        if (scaled_s > OUT_MAX) begin
            sat_s = 1'b1;
            q_s   = OUT_MAX[WORD_LEN_OUT-1:0];
        end else if (scaled_s < OUT_MIN) begin
            sat_s = 1'b1;
            q_s   = OUT_MIN[WORD_LEN_OUT-1:0];
        end else begin
            sat_s = 1'b0;
        end
    end

    // Next FIFO occupancy from push/pop pair.
    always_comb begin
        occ_nxt_s = occ_r;
        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + OCC_W'(1);
            2'b01:   occ_nxt_s = occ_r - OCC_W'(1);
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Group accumulator and sample counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (accept_s) begin
            if (last_s) begin
                acc_r <= '0;
                cnt_r <= '0;
            end else begin
                acc_r <= sum_s;
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Output FIFO storage, pointers and registered valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            occ_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= q_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            occ_r       <= occ_nxt_s;
            out_valid_r <= (occ_nxt_s != OCC_W'(0));
        end
    end

    // Sticky saturation flag; a new saturation beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag_r <= 1'b0;
        end else if (push_s && sat_s) begin
            sat_flag_r <= 1'b1;
        end else if (sat_clr) begin
            sat_flag_r <= 1'b0;
        end
    end

`ifdef IIR_DEC_SAT_CNT_EN
    logic [15:0] sat_cnt_r;

    // Saturating count of clipped pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt_r <= 16'd0;
        end else if (sat_clr) begin
            sat_cnt_r <= (push_s && sat_s) ? 16'd1 : 16'd0;
        end else if (push_s && sat_s && (sat_cnt_r != 16'hFFFF)) begin
            sat_cnt_r <= sat_cnt_r + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_r;
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = mem_r[rd_ptr_r];
    assign sat_flag      = sat_flag_r;
endmodule

// File: tb/tb_iir_out_decimator.sv
// Self-checking bench for iir_out_decimator: directed scenarios plus randomized traffic
// checked against a real-arithmetic averaging model.
module tb_iir_out_decimator;
    localparam int WORD_LEN_IN   = 16;
    localparam int WORD_FRAC_IN  = 14;
    localparam int WORD_LEN_OUT  = 16;
    localparam int WORD_FRAC_OUT = 15;
    localparam int DECIM_LOG2    = 2;
    localparam int FIFO_DEPTH    = 4;
    localparam int D             = 1 << DECIM_LOG2;
    localparam int S             = DECIM_LOG2 + WORD_FRAC_IN - WORD_FRAC_OUT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sat_clr = 1'b0;
    logic sat_flag;
`ifdef IIR_DEC_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    iir_out_decimator_if #(.WORD_LEN_IN(WORD_LEN_IN), .WORD_LEN_OUT(WORD_LEN_OUT)) bus ();

    iir_out_decimator #(
        .WORD_LEN_IN(WORD_LEN_IN), .WORD_FRAC_IN(WORD_FRAC_IN),
        .WORD_LEN_OUT(WORD_LEN_OUT), .WORD_FRAC_OUT(WORD_FRAC_OUT),
        .DECIM_LOG2(DECIM_LOG2), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .sat_flag(sat_flag),
        .sat_clr(sat_clr)
`ifdef IIR_DEC_SAT_CNT_EN
        ,
        .sat_cnt(sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference: average of D samples in real arithmetic, round half up, clamp.
    int          grp[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    bit          exp_sat = 1'b0;
    int          exp_sat_cnt = 0;

    function automatic logic [15:0] quant(input longint sum, output bit sat);
        real    r;
        longint e;
        longint hi;
        longint lo;
        hi  = (64'sd1 <<< (WORD_LEN_OUT - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (WORD_LEN_OUT - 1));
        r   = real'(sum) / (2.0 ** S);
        e   = longint'($floor(r + 0.5));
        sat = 1'b0;
        if (e > hi) begin
            e = hi;
            sat = 1'b1;
        end else if (e < lo) begin
            e = lo;
            sat = 1'b1;
        end
        return e[15:0];
    endfunction

    // Handshakes are stable mid-cycle; they complete at the following rising edge.
    always @(negedge clk) begin
        longint sum;
        bit     s;
        if (rst) begin
            grp.delete();
            exp_q.delete();
            got_q.delete();
            exp_sat = 1'b0;
            exp_sat_cnt = 0;
        end else begin
            if (sat_clr) begin
                exp_sat = 1'b0;
                exp_sat_cnt = 0;
            end
            if (bus.in_valid && bus.in_ready) begin
                grp.push_back(int'($signed(bus.in_data)));
                if (grp.size() == D) begin
                    sum = 0;
                    foreach (grp[i]) sum += grp[i];
                    exp_q.push_back(quant(sum, s));
                    if (s) begin
                        exp_sat = 1'b1;
                        if (exp_sat_cnt < 65535) exp_sat_cnt++;
                    end
                    grp.delete();
                end
            end
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
        end
    end

    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 100 && got_q.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_average();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'h1000);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL avg_early_valid: got %b want 0", bus.out_valid); end
        send(16'h1000);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL avg_latency: out_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h2000) begin errors++; $display("FAIL avg_value: got %h want 2000", bus.out_data); end
        bus.out_ready = 1'b1;
        wait_got(1);
        checks++; if (got_q.size() != 1 || got_q[0] !== 16'h2000) begin errors++; $display("FAIL avg_pop: count %0d want 1", got_q.size()); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_round();
        bus.out_ready = 1'b1;
        send(16'h0001); send(16'h0000); send(16'h0000); send(16'h0000);
        send(16'hFFFF); send(16'h0000); send(16'h0000); send(16'h0000);
        wait_got(2);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL round_count: got %0d want 2", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 16'h0001) begin errors++; $display("FAIL round_pos: got %h want 0001", got_q[0]); end
            checks++; if (got_q[1] !== 16'h0000) begin errors++; $display("FAIL round_neg: got %h want 0000", got_q[1]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(16'h7FFF);
        for (int i = 0; i < 4; i++) send(16'h8000);
        wait_got(2);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL sat_count: got %0d want 2", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %h want 7fff", got_q[0]); end
            checks++; if (got_q[1] !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %h want 8000", got_q[1]); end
        end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b want 1", sat_flag); end
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_clr: got %b want 0", sat_flag); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [15:0] head;
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < ((k == 5) ? 3 : 4); i++) send(16'(16'h0400 * k));
        end
        checks++; if (got_q.size() != 0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_fill: popped %0d valid %b want 0 and 1", got_q.size(), bus.out_valid); end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1400;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
        head = bus.out_data;
        repeat (3) @(negedge clk);
        checks++; if (bus.out_data !== 16'h0800 || head !== 16'h0800) begin errors++; $display("FAIL bp_head_stable: got %h then %h want 0800", head, bus.out_data); end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(16'h1400);
        wait_got(5);
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            checks++;
            if (got_q[i] !== 16'(16'h0800 * (i + 1))) begin
                errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], 16'(16'h0800 * (i + 1)));
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midgroup();
        bus.out_ready = 1'b1;
        send(16'h4000); send(16'h4000);
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_state: valid %b ready %b want 0 1", bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(16'h1000);
        wait_got(1);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (got_q.size() != 1 || got_q[0] !== 16'h2000) begin errors++; $display("FAIL mid_reset_out: count %0d first %h want 1 x 2000", got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_data   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8191) - 4096);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            sat_clr       = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        sat_clr       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (sat_flag !== exp_sat) begin errors++; $display("FAIL rand_sat_flag: got %b want %b", sat_flag, exp_sat); end
`ifdef IIR_DEC_SAT_CNT_EN
        checks++; if (sat_cnt !== 16'(exp_sat_cnt)) begin errors++; $display("FAIL rand_sat_cnt: got %0d want %0d", sat_cnt, exp_sat_cnt); end
`endif
        pulse_reset();
    endtask

`ifdef IIR_DEC_SAT_CNT_EN
    task automatic test_sat_cnt();
        bus.out_ready = 1'b1;
        checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL satcnt_reset: got %0d want 0", sat_cnt); end
        for (int g = 0; g < 3; g++) for (int i = 0; i < 4; i++) send(16'h7FFF);
        wait_got(3);
        checks++; if (sat_cnt !== 16'd3) begin errors++; $display("FAIL satcnt_three: got %0d want 3", sat_cnt); end
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL satcnt_clr: got %0d want 0", sat_cnt); end
        got_q.delete(); exp_q.delete();
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
        test_reset();
        test_average();
        test_round();
        test_saturation();
        test_backpressure();
        test_reset_midgroup();
        test_random();
`ifdef IIR_DEC_SAT_CNT_EN
        test_sat_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
